// File: rtl/wide_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wide_reg_pkg
// Description : Shared widths, controller state encoding and helpers for the
//               wide register loader.
// Revision    : 1.0 - initial release
// ============================================================================
package wide_reg_pkg;

    localparam int c_WORD_W = 32;
    localparam int c_WORDS  = 4;
    localparam int c_WIDE_W = c_WORD_W * c_WORDS;

    // Controller states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    // Word index width; a single-word configuration still needs one bit.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage : wide_reg_pkg
`default_nettype wire

// File: rtl/wide_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : wide_word_packer
// Description : Shadow register plus word index. Packs streamed words into
//               the wide value, loads the whole value at once for readback,
//               and presents the word currently selected by the index.
// Revision    : 1.0 - initial release
// ============================================================================
module wide_word_packer
    import wide_reg_pkg::*;
#(
    parameter int WORD_W = c_WORD_W,
    parameter int WORDS  = c_WORDS,
    localparam int WIDE_W = WORD_W * WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,      // return index to word 0
    input  logic              load_word,  // write word_in at index, advance
    input  logic              step,       // advance index only
    input  logic              load_wide,  // capture wide_in, index to 0
    input  logic [WORD_W-1:0] word_in,
    input  logic [WIDE_W-1:0] wide_in,
    output logic [WIDE_W-1:0] shadow,
    output logic [WORD_W-1:0] word_out,
    output logic              last        // index points at the final word
);

    localparam int c_IDX_W = idx_width(WORDS);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(WORDS - 1);

    logic [WIDE_W-1:0]  r_shadow;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_IDX_W-1:0] w_idx_nxt;

    // Index advance wraps explicitly so non-power-of-two word counts work.
    assign w_idx_nxt = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
    assign last      = (r_idx == c_IDX_LAST);
    assign shadow    = r_shadow;
    assign word_out  = r_shadow[r_idx*WORD_W +: WORD_W];

    // Shadow and index update; whole-value load takes priority over word ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_idx    <= '0;
        end else if (load_wide) begin
            r_shadow <= wide_in;
            r_idx    <= '0;
        end else if (clear) begin
            r_idx    <= '0;
        end else if (load_word) begin
            r_shadow[r_idx*WORD_W +: WORD_W] <= word_in;
            r_idx    <= w_idx_nxt;
        end else if (step) begin
            r_idx    <= w_idx_nxt;
        end
    end

endmodule : wide_word_packer
`default_nettype wire

// File: rtl/wide_reg_loader.sv
`default_nettype none
// ============================================================================
// Module      : wide_reg_loader
// Description : Loads a wide downstream register from a narrow word stream
//               (FILL then single-cycle COMMIT) and streams the register
//               back out word by word (DRAIN). Either transfer can be
//               aborted; a commit in flight always completes.
// Revision    : 1.0 - initial release
// ============================================================================
module wide_reg_loader
    import wide_reg_pkg::*;
#(
    parameter int WORD_W = c_WORD_W,
    parameter int WORDS  = c_WORDS,
    localparam int WIDE_W = WORD_W * WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rd_req,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [WORD_W-1:0] s_data,
    output logic              s_ready,
    output logic              reg_en,
    output logic [WIDE_W-1:0] reg_d,
    input  logic [WIDE_W-1:0] reg_q,
    output logic              m_valid,
    output logic [WORD_W-1:0] m_data,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_clear;
    logic              w_load_word;
    logic              w_step;
    logic              w_load_wide;
    logic              w_last;
    logic [WORD_W-1:0] w_word_out;
    logic [WIDE_W-1:0] w_shadow;

    wide_word_packer #(
        .WORD_W (WORD_W),
        .WORDS  (WORDS)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (w_clear),
        .load_word (w_load_word),
        .step      (w_step),
        .load_wide (w_load_wide),
        .word_in   (s_data),
        .wide_in   (reg_q),
        .shadow    (w_shadow),
        .word_out  (w_word_out),
        .last      (w_last)
    );

    // The downstream register always sees the shadow; only reg_en gates it.
    assign reg_d  = w_shadow;
    assign busy   = (r_state != ST_IDLE);
    assign m_data = m_valid ? w_word_out : '0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and output decode; abort skips the word op so a same-cycle
    // handshake is dropped, and COMMIT never looks at abort.
    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        reg_en      = 1'b0;
        done        = 1'b0;
        w_clear     = 1'b0;
        w_load_word = 1'b0;
        w_step      = 1'b0;
        w_load_wide = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_FILL;
                    w_clear     = 1'b1;
                end else if (rd_req) begin
                    w_state_nxt = ST_DRAIN;
                    w_load_wide = 1'b1;
                end
            end
            ST_FILL: begin
                s_ready = 1'b1;
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_clear     = 1'b1;
                end else if (s_valid) begin
                    w_load_word = 1'b1;
                    if (w_last) begin
                        w_state_nxt = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                reg_en      = 1'b1;
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
                m_valid = 1'b1;
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_clear     = 1'b1;
                end else if (m_ready) begin
                    w_step = 1'b1;
                    if (w_last) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule : wide_reg_loader
`default_nettype wire

// File: doc/wide_reg_loader.md
WIDE_REG_LOADER -- requirements
Module: wide_reg_loader

Interface
REQ-001 Parameter WORD_W, default 32, SHALL set the width of one streamed word.
REQ-002 Parameter WORDS, default 4, SHALL set the words per wide value; WIDE_W = WORD_W*WORDS (128).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL request a write transfer (sampled in IDLE).
REQ-006 rd_req  input  1  SHALL request a readback transfer (sampled in IDLE).
REQ-007 abort  input  1  SHALL cancel an in-progress FILL or DRAIN.
REQ-008 s_valid, s_data[WORD_W-1:0]  input  SHALL carry write words; s_ready  output  1  SHALL be the accept strobe.
REQ-009 reg_en  output  1, reg_d  output  WIDE_W  SHALL drive the load enable and data of the downstream 128-bit register.
REQ-010 reg_q  input  WIDE_W  SHALL be the current contents of that register.
REQ-011 m_valid  output  1, m_data  output  WORD_W  SHALL carry readback words; m_ready  input  1.
REQ-012 busy  output  1  SHALL be high in any state other than IDLE; done  output  1  SHALL pulse for one cycle on commit.

Function
REQ-013 States SHALL be IDLE, FILL, COMMIT, DRAIN; a 2-bit word index idx SHALL track position.
REQ-014 IDLE: start=1 -> FILL, idx=0; else rd_req=1 -> DRAIN, idx=0, shadow <= reg_q; start wins when both are high.
REQ-015 FILL: s_ready=1; on s_valid&s_ready, shadow[idx*WORD_W +: WORD_W] <= s_data, idx++; word 0 SHALL land in bits [31:0].
REQ-016 FILL: acceptance of word WORDS-1 -> COMMIT next cycle; s_ready SHALL be 0 in all other states.
REQ-017 COMMIT: reg_en=1 for exactly one cycle with reg_d = shadow; done=1 in the same cycle; next state IDLE.
REQ-018 reg_d SHALL always equal shadow; reg_en SHALL be 0 outside COMMIT.
REQ-019 Write latency: the final word handshake at cycle N SHALL give reg_en at N+1 and busy=0 at N+2.
REQ-020 DRAIN: m_valid=1, m_data = shadow word idx; on m_valid&m_ready, idx++; handshake on word WORDS-1 -> IDLE.
REQ-021 m_data SHALL stay stable while m_valid=1 and m_ready=0.
REQ-022 abort in FILL or DRAIN -> IDLE next cycle; no reg_en, no done; a word handshake in that same cycle SHALL be discarded.
REQ-023 abort in COMMIT or IDLE SHALL be ignored; the commit SHALL complete.
REQ-024 start or rd_req outside IDLE SHALL be ignored (not queued).
REQ-025 idx SHALL wrap to 0 on every return to IDLE.

Reset
REQ-026 While rst_n=0: state=IDLE, idx=0, shadow=0, so reg_d=0; reg_en, done, busy, s_ready, m_valid and m_data SHALL be 0.
REQ-027 Reset asserted mid-FILL or mid-DRAIN SHALL abandon the transfer with no reg_en pulse, before or after release.

Structure
REQ-028 Package wide_reg_pkg SHALL hold the state enum, WORD_W, WORDS and WIDE_W defaults.
REQ-029 Sub-module wide_word_packer SHALL hold the shadow register and idx with load-word, load-wide and clear controls; the FSM SHALL stay in the top.

Verification
REQ-030 Directed write: start, then words 0x11111111, 0x22222222, 0x33333333, 0x44444444 with s_valid held -> one reg_en cycle, reg_d=0x44444444_33333333_22222222_11111111, done=1.
REQ-031 Directed backpressure readback: rd_req with reg_q=0xDEADBEEF_CAFEF00D_01234567_89ABCDEF and m_ready low for 3 cycles per word -> m_data sequence 0x89ABCDEF, 0x01234567, 0xCAFEF00D, 0xDEADBEEF, each held stable while stalled.
REQ-032 Directed abort: abort after 2 write words -> IDLE next cycle, reg_en never asserted; a new write then commits only its own 4 words.
REQ-033 Directed start and rd_req both high in IDLE -> FILL entered, m_valid stays 0.
REQ-034 Directed reset mid-FILL: rst_n low after word 3 -> all outputs 0 immediately, no reg_en after release.
REQ-035 Directed abort in COMMIT cycle -> reg_en and done still pulse once.
